// File: rtl/ud_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep controller.
//   state_e  : FSM state encoding (ST_IDLE/ST_UP/ST_DOWN/ST_DONE)
//   DIR_UP   : direction select for counting up (also the counter mux select)
//   DIR_DOWN : direction select for counting down
package ud_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ud_sweep_ctrl_if.sv
// Control/status bundle between a control master and the sweep controller.
//   start, abort       : run request / immediate stop (master -> controller)
//   lo, hi, n_sweeps   : sweep bounds and sweep count, sampled with start
//   cnt, up_down       : counter value and direction select (controller -> master)
//   busy, done, cfg_err: run status, completion pulse, bad-config pulse
//   sweep_cnt          : completed sweeps in the current run
interface ud_sweep_ctrl_if
    import ud_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SWEEP_W = 8
);
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [SWEEP_W-1:0] n_sweeps;
    logic [WIDTH-1:0]   cnt;
    logic               up_down;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
        output start, abort, lo, hi, n_sweeps,
        input  cnt, up_down, busy, done, cfg_err, sweep_cnt
    );

    modport slave (
        input  start, abort, lo, hi, n_sweeps,
        output cnt, up_down, busy, done, cfg_err, sweep_cnt
    );

endinterface

// File: rtl/ud_sweep_ctrl_counter_ld.sv
// Up/down counter with enable and synchronous load.
//   clk, rst : clock, asynchronous active-high reset (cnt -> 0)
//   en       : count one step in direction dir
//   load     : load load_val (takes priority over en)
//   load_val : value to load
//   dir      : DIR_UP counts up, DIR_DOWN counts down
//   cnt      : registered count
module ud_sweep_ctrl_counter_ld
    import ud_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (dir == DIR_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ud_sweep_ctrl.sv
// Triangle-sweep sequencer: drives the counter lo -> hi -> lo, n_sweeps times
// (0 = until abort), then pulses done. Holds the FSM, bound registers and the
// sweep counter; the counter itself lives in ud_sweep_ctrl_counter_ld.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ud_sweep_ctrl_if (start/abort/config in, status out)
module ud_sweep_ctrl
    import ud_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SWEEP_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    ud_sweep_ctrl_if.slave bus
);

    state_e             state_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [SWEEP_W-1:0] n_q;
    logic [SWEEP_W-1:0] sweep_q;
    logic               up_down_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic [WIDTH-1:0]   cnt;
    logic               cnt_en;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_load_val;
    logic               cnt_dir;

    logic               cfg_ok;
    logic               at_hi;
    logic               at_lo;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               last_sweep;

    assign cfg_ok     = bus.lo < bus.hi;
    assign at_hi      = cnt == hi_q;
    assign at_lo      = cnt == lo_q;
    assign sweep_inc  = sweep_q + SWEEP_W'(1);
    // n_q == 0 means continuous; sweep_q then wraps freely.
    assign last_sweep = (n_q != '0) && (sweep_inc == n_q);

    // Counter controls. Abort leaves en/load low so cnt freezes.
    always_comb begin
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = cnt;
        cnt_dir      = DIR_UP;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && cfg_ok) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = bus.lo;
                end
            end
            ST_UP: begin
                if (!bus.abort) begin
                    if (!at_hi) begin
                        cnt_en = 1'b1;
                    end else begin
                        // Turn around so hi is shown for exactly one cycle.
                        cnt_load     = 1'b1;
                        cnt_load_val = hi_q - WIDTH'(1);
                    end
                end
            end
            ST_DOWN: begin
                cnt_dir = DIR_DOWN;
                if (!bus.abort) begin
                    if (!at_lo) begin
                        cnt_en = 1'b1;
                    end else if (!last_sweep) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = lo_q + WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            sweep_q   <= '0;
            up_down_q <= DIR_UP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // abort is deliberately not looked at here: start wins.
                    if (bus.start) begin
                        if (cfg_ok) begin
                            lo_q      <= bus.lo;
                            hi_q      <= bus.hi;
                            n_q       <= bus.n_sweeps;
                            sweep_q   <= '0;
                            state_q   <= ST_UP;
                            busy_q    <= 1'b1;
                            up_down_q <= DIR_UP;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (bus.abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        up_down_q <= DIR_UP;
                    end else if (at_hi) begin
                        state_q   <= ST_DOWN;
                        up_down_q <= DIR_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (bus.abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        up_down_q <= DIR_UP;
                    end else if (at_lo) begin
                        sweep_q   <= sweep_inc;
                        up_down_q <= DIR_UP;
                        if (last_sweep) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_UP;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    ud_sweep_ctrl_counter_ld #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dir      (cnt_dir),
        .cnt      (cnt)
    );

    assign bus.cnt       = cnt;
    assign bus.up_down   = up_down_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.sweep_cnt = sweep_q;

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// Directed bench for ud_sweep_ctrl with hand-computed expectations.
module tb_ud_sweep_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [7:0] snap;

    ud_sweep_ctrl_if #(.WIDTH(8), .SWEEP_W(8)) bus ();

    ud_sweep_ctrl #(.WIDTH(8), .SWEEP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] l, input logic [7:0] h, input logic [7:0] n);
        bus.start    = 1'b1;
        bus.lo       = l;
        bus.hi       = h;
        bus.n_sweeps = n;
        tick();
        bus.start = 1'b0;
    endtask

    logic [7:0] t1_cnt[7] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2};
    logic       t1_ud [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] t2_cnt[7] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    logic       t2_ud [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.lo       = '0;
        bus.hi       = '0;
        bus.n_sweeps = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_up_down", 32'(bus.up_down), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 0);
        chk("rst_sweep_cnt", 32'(bus.sweep_cnt), 0);

        // 1: lo=2 hi=5 n=1
        go(8'd2, 8'd5, 8'd1);
        for (int i = 0; i < 7; i++) begin
            chk("t1_cnt", 32'(bus.cnt), 32'(t1_cnt[i]));
            chk("t1_up_down", 32'(bus.up_down), 32'(t1_ud[i]));
            chk("t1_busy", 32'(bus.busy), 1);
            chk("t1_done_low", 32'(bus.done), 0);
            if (i < 6) tick();
        end
        tick();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_busy_off", 32'(bus.busy), 0);
        chk("t1_cnt_hold", 32'(bus.cnt), 2);
        chk("t1_sweep_cnt", 32'(bus.sweep_cnt), 1);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 0);

        // 2: lo=0 hi=1 n=3
        go(8'd0, 8'd1, 8'd3);
        for (int i = 0; i < 7; i++) begin
            chk("t2_cnt", 32'(bus.cnt), 32'(t2_cnt[i]));
            chk("t2_up_down", 32'(bus.up_down), 32'(t2_ud[i]));
            chk("t2_done_low", 32'(bus.done), 0);
            if (i < 6) tick();
        end
        tick();
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_sweep_cnt", 32'(bus.sweep_cnt), 3);
        tick();
        chk("t2_done_once", 32'(bus.done), 0);

        // 3: bad configs
        go(8'd7, 8'd7, 8'd1);
        chk("t3a_cfg_err", 32'(bus.cfg_err), 1);
        chk("t3a_busy", 32'(bus.busy), 0);
        chk("t3a_cnt", 32'(bus.cnt), 0);
        tick();
        chk("t3a_cfg_err_pulse", 32'(bus.cfg_err), 0);
        chk("t3a_busy2", 32'(bus.busy), 0);
        go(8'd9, 8'd3, 8'd1);
        chk("t3b_cfg_err", 32'(bus.cfg_err), 1);
        chk("t3b_busy", 32'(bus.busy), 0);
        chk("t3b_cnt", 32'(bus.cnt), 0);
        tick();
        chk("t3b_cfg_err_pulse", 32'(bus.cfg_err), 0);

        // 4: continuous lo=250 hi=255, then abort at the lo turnaround
        go(8'd250, 8'd255, 8'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t4_cnt_range", 32'(bus.cnt >= 8'd250 && bus.cnt <= 8'd255), 1);
            chk("t4_no_done", 32'(bus.done), 0);
        end
        chk("t4_cnt", 32'(bus.cnt), 250);
        chk("t4_up_down", 32'(bus.up_down), 1);
        chk("t4_sweep_cnt", 32'(bus.sweep_cnt), 3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_abort_busy", 32'(bus.busy), 0);
        chk("t4_abort_cnt", 32'(bus.cnt), 250);
        chk("t4_abort_sweep", 32'(bus.sweep_cnt), 3);
        chk("t4_abort_done", 32'(bus.done), 0);
        tick();
        chk("t4_frozen_cnt", 32'(bus.cnt), 250);
        chk("t4_frozen_done", 32'(bus.done), 0);

        // 5: mid-run start ignored; abort on final lo suppresses done
        go(8'd2, 8'd4, 8'd2);
        tick();
        bus.start    = 1'b1;
        bus.lo       = 8'd10;
        bus.hi       = 8'd20;
        bus.n_sweeps = 8'd1;
        tick();
        bus.start = 1'b0;
        chk("t5_ignore_start", 32'(bus.cnt), 4);
        chk("t5_busy", 32'(bus.busy), 1);
        tick();
        chk("t5_down", 32'(bus.up_down), 1);
        tick();
        tick();
        chk("t5_reup_cnt", 32'(bus.cnt), 3);
        chk("t5_reup_dir", 32'(bus.up_down), 0);
        tick();
        tick();
        tick();
        chk("t5_final_lo", 32'(bus.cnt), 2);
        chk("t5_sweep_before", 32'(bus.sweep_cnt), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_abort_done", 32'(bus.done), 0);
        chk("t5_abort_busy", 32'(bus.busy), 0);
        chk("t5_abort_dir", 32'(bus.up_down), 0);
        chk("t5_abort_cnt", 32'(bus.cnt), 2);
        chk("t5_abort_sweep", 32'(bus.sweep_cnt), 1);
        tick();
        chk("t5_no_late_done", 32'(bus.done), 0);

        // 6: async reset during DOWN at cnt=4, then fresh run
        go(8'd2, 8'd6, 8'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_pre_cnt", 32'(bus.cnt), 4);
        chk("t6_pre_dir", 32'(bus.up_down), 1);
        snap = bus.cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", 32'(bus.cnt), 0);
        chk("t6_rst_dir", 32'(bus.up_down), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        #1;
        rst = 1'b0;
        tick();
        chk("t6_idle_cnt", 32'(bus.cnt), 0);
        go(8'd1, 8'd3, 8'd1);
        chk("t6_new_cnt", 32'(bus.cnt), 1);
        chk("t6_new_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_new_done", 32'(bus.done), 1);
        chk("t6_new_cnt_end", 32'(bus.cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
